dmem_port_arbiter: RTL and testbench
====================================

Name: dmem_port_arbiter

Overview:
Shares the single data-memory port between the two issue pipes of the superscalar core (pipe 0 and pipe 1 MEM stages). It has a small FSM that latches one request, drives a multi-cycle ready/valid memory transaction, and returns read data plus a one-cycle done pulse. It also raises per-pipe stall signals that feed the hazard detection / PC-hold logic. Ties are resolved round-robin.

Parameters:
ADDR_W, 32, address width of requests and memory port
DATA_W, 32, data width of read/write data
TIMEOUT_CYCLES, 16, watchdog limit in BUSY (used only with ARB_TIMEOUT_EN)

Ports:
clk  in  1  single clock, rising edge
reset  in  1  synchronous, active-high reset
req0  in  1  pipe 0 memory request (level, held until done0)
we0  in  1  pipe 0 write enable (1=store, 0=load)
addr0  in  ADDR_W  pipe 0 address
wdata0  in  DATA_W  pipe 0 store data
req1, we1, addr1, wdata1  in  1/1/ADDR_W/DATA_W  same as above, for pipe 1
done0  out  1  one-cycle pulse: pipe 0 transaction complete
done1  out  1  one-cycle pulse: pipe 1 transaction complete
stall0  out  1  pipe 0 must hold (req0 & ~done0)
stall1  out  1  pipe 1 must hold (req1 & ~done1)
rdata  out  DATA_W  load data for the pipe whose done is high
err  out  1  one-cycle pulse with done when the transaction timed out
mem_req  out  1  memory request, registered
mem_we  out  1  memory write enable, registered
mem_addr  out  ADDR_W  memory address, registered
mem_wdata  out  DATA_W  memory write data, registered
mem_ready  in  1  memory completes the current transaction this cycle
mem_rdata  in  DATA_W  memory read data, valid when mem_ready=1

Behaviour:
- Clocking/reset: one clock, clk. reset is synchronous and active-high.
- State on reset: state=IDLE; last_grant=1, so pipe 0 wins the first tie.
- Output values on reset: mem_req, mem_we, done0, done1, err = 0; mem_addr, mem_wdata, rdata = 0.
- FSM has three states: IDLE, BUSY, RESP.
- IDLE, no request: stays IDLE; all strobes are 0.
- IDLE, exactly one req: grants that pipe.
- IDLE, both req: grants the pipe not equal to last_grant.
- On grant:
  - Latch we/addr/wdata into mem_we/mem_addr/mem_wdata, set mem_req=1, record the grant in cur, update last_grant, go to BUSY.
  - Latency: req sampled at edge N gives mem_req high from edge N.
- BUSY, mem_ready=0: hold mem_req and all mem_* outputs stable.
- BUSY, mem_ready=1 at an edge:
  - Drop mem_req.
  - If the transaction is a load, register mem_rdata into rdata.
  - Go to RESP.
- RESP: exactly one cycle.
  - done[cur]=1; the other done stays 0.
  - rdata holds the loaded value. It is unchanged for stores (holds the last load value).
  - The req of the served pipe is ignored this cycle. The requester must deassert or replace it before the next edge.
  - Next state is IDLE.
- Minimum transaction cost: grant edge, then one or more BUSY cycles, then one RESP cycle. Back-to-back requests therefore take ≥3 cycles each. The arbiter never issues a new mem_req in the cycle after mem_ready.
- stall0/stall1 are combinational from req and done, so a requesting pipe stalls every cycle except its done cycle.
- The unserved pipe keeps its req high and is granted on the next IDLE. Starvation is impossible, because a pipe that loses a tie wins the next one.
- Reset mid-transaction: return to IDLE at the edge and drop mem_req. The outstanding memory access is abandoned. No done pulse is generated.
- mem_ready outside BUSY is ignored.
- Request signals changing while their pipe is in BUSY have no effect, because values are latched at grant.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- When defined:
  - A cycle counter counts up from 0 on BUSY entry.
  - If TIMEOUT_CYCLES cycles pass in BUSY with mem_ready=0, drop mem_req, set rdata=0, and go to RESP. In RESP, err=1 together with done[cur].
  - mem_ready on the same edge as the timeout takes priority (normal completion, err=0).
- When not defined: there is no counter, BUSY waits indefinitely, and err is tied to 0.

Test Plan:
1. Reset held 2 cycles, then released with no req → all outputs 0, no mem_req for 10 cycles.
2. req0 load, addr0=0x40; memory returns mem_rdata=0xDEADBEEF with mem_ready after 3 BUSY cycles → mem_addr=0x40, mem_we=0; done0 pulses once; rdata=0xDEADBEEF; stall0 high until done0.
3. req0 and req1 asserted on the same edge from reset; stores to 0x10 and 0x20 → pipe 0 served first, then pipe 1. Repeat the tie → pipe 1 is now served first (round-robin).
4. Pipe 0 in BUSY when reset is asserted → next edge gives IDLE, mem_req=0, no done0. A following request is served normally.
5. Store wdata1=0x12345678 after a prior load of 0xDEADBEEF → mem_we=1, mem_wdata=0x12345678; done1 pulses; rdata stays 0xDEADBEEF.
6. With ARB_TIMEOUT_EN, mem_ready held 0 → exactly TIMEOUT_CYCLES=16 BUSY cycles, then done0=err=1 and rdata=0. Without the macro, the arbiter stays in BUSY with err=0.

Source files
------------

// File: rtl/dmem_port_arbiter.sv
// Round-robin arbiter sharing one ready/valid data-memory port between two MEM pipes.
// Optional BUSY watchdog enabled by defining ARB_TIMEOUT_EN.
module dmem_port_arbiter #(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              done0,
  output logic              done1,
  output logic              stall0,
  output logic              stall1,
  output logic [DATA_W-1:0] rdata,
  output logic              err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
    $error("dmem_port_arbiter: TIMEOUT_CYCLES must be at least 1");
  end

  state_t              state, state_nxt;
  logic                last_grant, last_grant_nxt;
  logic                cur, cur_nxt;
  logic                gnt;
  logic                mem_req_nxt, mem_we_nxt;
  logic [ADDR_W-1:0]   mem_addr_nxt;
  logic [DATA_W-1:0]   mem_wdata_nxt, rdata_nxt;
  logic                done0_nxt, done1_nxt;

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             err_nxt;
`endif

  // Stall is combinational so the pipe is released in the very cycle done rises.
  assign stall0 = req0 & ~done0;
  assign stall1 = req1 & ~done1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      cur        <= 1'b0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      rdata      <= '0;
      done0      <= 1'b0;
      done1      <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      cnt        <= '0;
      err        <= 1'b0;
`endif
    end else begin
      state      <= state_nxt;
      last_grant <= last_grant_nxt;
      cur        <= cur_nxt;
      mem_req    <= mem_req_nxt;
      mem_we     <= mem_we_nxt;
      mem_addr   <= mem_addr_nxt;
      mem_wdata  <= mem_wdata_nxt;
      rdata      <= rdata_nxt;
      done0      <= done0_nxt;
      done1      <= done1_nxt;
`ifdef ARB_TIMEOUT_EN
      cnt        <= cnt_nxt;
      err        <= err_nxt;
`endif
    end
  end

`ifndef ARB_TIMEOUT_EN
  assign err = 1'b0;
`endif

  always_comb begin
    state_nxt      = state;
    last_grant_nxt = last_grant;
    cur_nxt        = cur;
    mem_req_nxt    = mem_req;
    mem_we_nxt     = mem_we;
    mem_addr_nxt   = mem_addr;
    mem_wdata_nxt  = mem_wdata;
    rdata_nxt      = rdata;
    done0_nxt      = 1'b0;
    done1_nxt      = 1'b0;
`ifdef ARB_TIMEOUT_EN
    cnt_nxt        = cnt;
    err_nxt        = 1'b0;
`endif
    // On a tie the pipe that did not win last time is chosen.
    gnt = (req0 && req1) ? ~last_grant : req1;

    case (state)
      IDLE: begin
        if (req0 || req1) begin
          state_nxt      = BUSY;
          cur_nxt        = gnt;
          last_grant_nxt = gnt;
          mem_req_nxt    = 1'b1;
          mem_we_nxt     = gnt ? we1 : we0;
          mem_addr_nxt   = gnt ? addr1 : addr0;
          mem_wdata_nxt  = gnt ? wdata1 : wdata0;
`ifdef ARB_TIMEOUT_EN
          cnt_nxt        = '0;
`endif
        end
      end
      BUSY: begin
        if (mem_ready) begin
          state_nxt   = RESP;
          mem_req_nxt = 1'b0;
          done0_nxt   = ~cur;
          done1_nxt   = cur;
          if (!mem_we) begin
            rdata_nxt = mem_rdata;
          end
        end
`ifdef ARB_TIMEOUT_EN
        else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          state_nxt   = RESP;
          mem_req_nxt = 1'b0;
          done0_nxt   = ~cur;
          done1_nxt   = cur;
          rdata_nxt   = '0;
          err_nxt     = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
`endif
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed self-checking bench for dmem_port_arbiter; outputs sampled on the falling edge.
module tb_dmem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0, we0, req1, we1;
  logic [31:0] addr0, wdata0, addr1, wdata1;
  logic        done0, done1, stall0, stall1, err;
  logic [31:0] rdata;
  logic        mem_req, mem_we, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dmem_port_arbiter dut (
    .clk(clk), .reset(reset),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .done0(done0), .done1(done1), .stall0(stall0), .stall1(stall1),
    .rdata(rdata), .err(err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  // Waits (bounded) for mem_req, holds BUSY for 'busy' cycles, returns at the RESP cycle.
  task automatic run_txn(input int busy, input logic [31:0] rd, output logic to,
                         output logic g_we, output logic [31:0] g_addr, output logic [31:0] g_wdata,
                         output logic d0, output logic d1, output logic e, output logic [31:0] g_rdata);
    to = 1'b1; g_we = 1'b0; g_addr = '0; g_wdata = '0; d0 = 1'b0; d1 = 1'b0; e = 1'b0; g_rdata = '0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (mem_req === 1'b1) begin
        to = 1'b0;
        break;
      end
    end
    if (!to) begin
      g_we = mem_we; g_addr = mem_addr; g_wdata = mem_wdata;
      repeat (busy - 1) @(negedge clk);
      mem_ready = 1'b1; mem_rdata = rd;
      @(negedge clk);
      mem_ready = 1'b0; mem_rdata = '0;
      d0 = done0; d1 = done1; e = err; g_rdata = rdata;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req0 = 0; we0 = 0; addr0 = '0; wdata0 = '0;
    req1 = 0; we1 = 0; addr1 = '0; wdata1 = '0;
    mem_ready = 0; mem_rdata = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (i == 4) begin mem_ready = 1'b1; mem_rdata = 32'hFFFF_FFFF; end
      if (i == 5) begin mem_ready = 1'b0; mem_rdata = '0; end
      @(negedge clk);
      checks++;
      if ({mem_req, mem_we, done0, done1, err, stall0, stall1, mem_addr, mem_wdata, rdata} !== '0) begin
        errors++;
        $display("FAIL reset_idle cyc%0d: req=%b we=%b d0=%b d1=%b err=%b addr=%h wdata=%h rdata=%h want all 0",
                 i, mem_req, mem_we, done0, done1, err, mem_addr, mem_wdata, rdata);
      end
    end
  endtask

  task automatic test_load();
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'h40;
    #1;
    checks++;
    if (stall0 !== 1'b1 || mem_req !== 1'b0) begin
      errors++; $display("FAIL load_pre: stall0=%b mem_req=%b want 1 0", stall0, mem_req);
    end
    for (int b = 1; b <= 3; b++) begin
      @(negedge clk);
      checks++;
      if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h40 || stall0 !== 1'b1 || done0 !== 1'b0) begin
        errors++;
        $display("FAIL load_busy%0d: req=%b we=%b addr=%h stall0=%b done0=%b want 1 0 00000040 1 0",
                 b, mem_req, mem_we, mem_addr, stall0, done0);
      end
      if (b == 3) begin mem_ready = 1'b1; mem_rdata = 32'hDEAD_BEEF; end
    end
    @(negedge clk);
    mem_ready = 1'b0; mem_rdata = '0;
    checks++;
    if (done0 !== 1'b1 || done1 !== 1'b0 || rdata !== 32'hDEAD_BEEF || stall0 !== 1'b0 || mem_req !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL load_resp: done0=%b done1=%b rdata=%h stall0=%b mem_req=%b err=%b want 1 0 deadbeef 0 0 0",
               done0, done1, rdata, stall0, mem_req, err);
    end
    req0 = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (done0 !== 1'b0 || mem_req !== 1'b0 || rdata !== 32'hDEAD_BEEF) begin
        errors++;
        $display("FAIL load_after%0d: done0=%b mem_req=%b rdata=%h want 0 0 deadbeef", i, done0, mem_req, rdata);
      end
    end
  endtask

  task automatic test_store_keeps_rdata();
    logic to, g_we, d0, d1, e;
    logic [31:0] g_addr, g_wdata, g_rd;
    req1 = 1'b1; we1 = 1'b1; addr1 = 32'h24; wdata1 = 32'h1234_5678;
    run_txn(2, 32'hBAD0_BAD0, to, g_we, g_addr, g_wdata, d0, d1, e, g_rd);
    req1 = 1'b0;
    checks++;
    if (to || g_we !== 1'b1 || g_addr !== 32'h24 || g_wdata !== 32'h1234_5678) begin
      errors++;
      $display("FAIL store_issue: timeout=%b we=%b addr=%h wdata=%h want 0 1 00000024 12345678", to, g_we, g_addr, g_wdata);
    end
    checks++;
    if (d1 !== 1'b1 || d0 !== 1'b0 || e !== 1'b0 || g_rd !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL store_resp: done1=%b done0=%b err=%b rdata=%h want 1 0 0 deadbeef", d1, d0, e, g_rd);
    end
    @(negedge clk);
  endtask

  task automatic test_round_robin();
    logic to, g_we, d0, d1, e;
    logic [31:0] g_addr, g_wdata, g_rd;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    req0 = 1'b1; we0 = 1'b1; addr0 = 32'h10; wdata0 = 32'hAAAA_0001;
    req1 = 1'b1; we1 = 1'b1; addr1 = 32'h20; wdata1 = 32'hBBBB_0002;
    run_txn(2, '0, to, g_we, g_addr, g_wdata, d0, d1, e, g_rd);
    checks++;
    if (to || g_addr !== 32'h10 || g_wdata !== 32'hAAAA_0001 || d0 !== 1'b1 || d1 !== 1'b0 || stall1 !== 1'b1) begin
      errors++;
      $display("FAIL rr_first: timeout=%b addr=%h wdata=%h d0=%b d1=%b stall1=%b want 0 00000010 aaaa0001 1 0 1",
               to, g_addr, g_wdata, d0, d1, stall1);
    end
    // pipe 0 immediately issues another store, creating a second tie
    addr0 = 32'h14; wdata0 = 32'hCCCC_0003;
    run_txn(1, '0, to, g_we, g_addr, g_wdata, d0, d1, e, g_rd);
    req1 = 1'b0;
    checks++;
    if (to || g_addr !== 32'h20 || g_wdata !== 32'hBBBB_0002 || d1 !== 1'b1 || d0 !== 1'b0 || stall0 !== 1'b1) begin
      errors++;
      $display("FAIL rr_second: timeout=%b addr=%h wdata=%h d1=%b d0=%b stall0=%b want 0 00000020 bbbb0002 1 0 1",
               to, g_addr, g_wdata, d1, d0, stall0);
    end
    run_txn(1, '0, to, g_we, g_addr, g_wdata, d0, d1, e, g_rd);
    req0 = 1'b0;
    checks++;
    if (to || g_addr !== 32'h14 || g_wdata !== 32'hCCCC_0003 || d0 !== 1'b1 || d1 !== 1'b0 || g_rd !== 32'h0) begin
      errors++;
      $display("FAIL rr_third: timeout=%b addr=%h wdata=%h d0=%b d1=%b rdata=%h want 0 00000014 cccc0003 1 0 0",
               to, g_addr, g_wdata, d0, d1, g_rd);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic to, g_we, d0, d1, e;
    logic [31:0] g_addr, g_wdata, g_rd;
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'h80;
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b1) begin errors++; $display("FAIL mid_busy: mem_req=%b want 1", mem_req); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (mem_req !== 1'b0 || done0 !== 1'b0 || done1 !== 1'b0 || rdata !== 32'h0) begin
      errors++;
      $display("FAIL mid_reset: mem_req=%b done0=%b done1=%b rdata=%h want 0 0 0 0", mem_req, done0, done1, rdata);
    end
    run_txn(1, 32'h55AA_55AA, to, g_we, g_addr, g_wdata, d0, d1, e, g_rd);
    req0 = 1'b0;
    checks++;
    if (to || g_we !== 1'b0 || g_addr !== 32'h80 || d0 !== 1'b1 || d1 !== 1'b0 || g_rd !== 32'h55AA_55AA) begin
      errors++;
      $display("FAIL mid_retry: timeout=%b we=%b addr=%h d0=%b d1=%b rdata=%h want 0 0 00000080 1 0 55aa55aa",
               to, g_we, g_addr, d0, d1, g_rd);
    end
    @(negedge clk);
  endtask

  task automatic test_timeout();
    logic bad;
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'h100;
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b1) begin errors++; $display("FAIL to_grant: mem_req=%b want 1", mem_req); end
`ifdef ARB_TIMEOUT_EN
    bad = 1'b0;
    for (int i = 2; i <= 16; i++) begin
      @(negedge clk);
      if (mem_req !== 1'b1 || done0 !== 1'b0 || err !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin errors++; $display("FAIL to_wait: busy ended early, last mem_req=%b done0=%b want 1 0", mem_req, done0); end
    @(negedge clk);
    checks++;
    if (done0 !== 1'b1 || err !== 1'b1 || rdata !== 32'h0 || mem_req !== 1'b0) begin
      errors++;
      $display("FAIL to_expire: done0=%b err=%b rdata=%h mem_req=%b want 1 1 0 0", done0, err, rdata, mem_req);
    end
    req0 = 1'b0;
    @(negedge clk);
    checks++;
    if (done0 !== 1'b0 || err !== 1'b0) begin
      errors++; $display("FAIL to_after: done0=%b err=%b want 0 0", done0, err);
    end
`else
    bad = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if ({mem_req, err, done0, stall0} !== 4'b1001) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL to_hold: req/err/done0/stall0=%b%b%b%b want 1001", mem_req, err, done0, stall0);
    end
    mem_ready = 1'b1; mem_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    mem_ready = 1'b0; mem_rdata = '0;
    checks++;
    if (done0 !== 1'b1 || err !== 1'b0 || rdata !== 32'hCAFE_F00D) begin
      errors++; $display("FAIL to_late_done: done0=%b err=%b rdata=%h want 1 0 cafef00d", done0, err, rdata);
    end
    req0 = 1'b0;
    @(negedge clk);
`endif
  endtask

  initial begin
    test_reset();
    test_load();
    test_store_keeps_rdata();
    test_round_robin();
    test_reset_mid();
    test_timeout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
